// File: rtl/mips_gcd_top.sv
// Single-cycle MIPS-subset core with a fixed Euclid-by-subtraction program in ROM.
// Operands come from the switches (data words 4/5); the result lands in data word 3.
module mips_gcd_top (
  input  logic       clk,
  input  logic       rst,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic       i5,
  input  logic       i6,
  input  logic       i7,
  input  logic       i8,
  input  logic       i9,
  input  logic       i10,
  input  logic       i11,
  input  logic       i12,
  input  logic       i13,
  input  logic       i14,
  input  logic       i15,
  output logic [7:0] gcd,
  output logic       done
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [7:0]  opa, opb;
  logic [31:0] pc, pc_plus4, pc_next, instr;
  logic [31:0] rf [32];
  logic [31:0] dmem [8];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] sext_imm, rs_val, rt_val, mem_addr, mem_rdata;
  logic [31:0] br_target, j_target;
  logic [2:0]  word_addr;

  logic        reg_we, mem_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;

  assign opa = {i7, i6, i5, i4, i3, i2, i1, i0};
  assign opb = {i15, i14, i13, i12, i11, i10, i9, i8};

  always_comb begin
    instr = 32'h0000_0000;
    case (pc[5:2])
      4'd0:  instr = 32'h8C01_0010; // lw  $1,16($0)
      4'd1:  instr = 32'h8C02_0014; // lw  $2,20($0)
      4'd2:  instr = 32'h1020_000A; // beq $1,$0,0x34
      4'd3:  instr = 32'h1040_0007; // beq $2,$0,0x2C
      4'd4:  instr = 32'h1022_0006; // beq $1,$2,0x2C
      4'd5:  instr = 32'h0022_182A; // slt $3,$1,$2
      4'd6:  instr = 32'h1060_0002; // beq $3,$0,0x24
      4'd7:  instr = 32'h0041_1022; // sub $2,$2,$1
      4'd8:  instr = 32'h0800_0004; // j   0x10
      4'd9:  instr = 32'h0022_0822; // sub $1,$1,$2
      4'd10: instr = 32'h0800_0004; // j   0x10
      4'd11: instr = 32'hAC01_000C; // sw  $1,12($0)
      4'd12: instr = 32'h0800_000C; // j   0x30 (halt)
      4'd13: instr = 32'hAC02_000C; // sw  $2,12($0)
      4'd14: instr = 32'h0800_000C; // j   0x30
      default: instr = 32'h0000_0000;
    endcase
  end

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};

  assign rs_val = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : rf[rt];

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};

  assign mem_addr  = rs_val + sext_imm;
  assign word_addr = mem_addr[4:2];

  // Words 4 and 5 are the switches, never the backing storage.
  always_comb begin
    case (word_addr)
      3'd4:    mem_rdata = {24'h0, opa};
      3'd5:    mem_rdata = {24'h0, opb};
      default: mem_rdata = dmem[word_addr];
    endcase
  end

  always_comb begin
    reg_we    = 1'b0;
    reg_waddr = rt;
    reg_wdata = 32'h0;
    mem_we    = 1'b0;
    pc_next   = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        reg_waddr = rd;
        case (funct)
          FN_ADD: begin reg_we = 1'b1; reg_wdata = rs_val + rt_val; end
          FN_SUB: begin reg_we = 1'b1; reg_wdata = rs_val - rt_val; end
          FN_AND: begin reg_we = 1'b1; reg_wdata = rs_val & rt_val; end
          FN_SLT: begin
            reg_we    = 1'b1;
            reg_wdata = {31'h0, $signed(rs_val) < $signed(rt_val)};
          end
          default: reg_we = 1'b0;
        endcase
      end
      OP_LW: begin
        reg_we    = 1'b1;
        reg_wdata = mem_rdata;
      end
      OP_SW:  mem_we = 1'b1;
      OP_BEQ: if (rs_val == rt_val) pc_next = br_target;
      OP_J:   pc_next = j_target;
      default: pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= 32'h0;
      for (int k = 0; k < 32; k++) rf[k] <= 32'h0;
      for (int k = 0; k < 8; k++) dmem[k] <= 32'h0;
    end else begin
      pc <= pc_next;
      if (reg_we && reg_waddr != 5'd0) rf[reg_waddr] <= reg_wdata;
      if (mem_we && word_addr != 3'd4 && word_addr != 3'd5) dmem[word_addr] <= rt_val;
    end
  end

  assign gcd  = dmem[3][7:0];
  assign done = (pc == 32'h0000_0030);

  logic unused_bits;
  assign unused_bits = ^{instr[10:6], mem_addr[31:5], mem_addr[1:0]};

endmodule

// File: tb/tb_mips_gcd_top.sv
// Randomised and directed bench for mips_gcd_top against an arithmetic GCD model.
module tb_mips_gcd_top;

  logic       clk;
  logic       rst;
  logic [7:0] opa, opb;
  logic [7:0] gcd;
  logic       done;

  int total = 0;
  int bad   = 0;

  mips_gcd_top dut (
    .clk (clk),
    .rst (rst),
    .i0  (opa[0]), .i1 (opa[1]), .i2 (opa[2]), .i3 (opa[3]),
    .i4  (opa[4]), .i5 (opa[5]), .i6 (opa[6]), .i7 (opa[7]),
    .i8  (opb[0]), .i9 (opb[1]), .i10(opb[2]), .i11(opb[3]),
    .i12 (opb[4]), .i13(opb[5]), .i14(opb[6]), .i15(opb[7]),
    .gcd (gcd),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int t;
    if (a == 0) return b;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Hold reset across a clock edge, then release it at a falling edge.
  task automatic restart(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst = 1'b0;
    opa = a;
    opb = b;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_done(input string tag, output int edges);
    edges = 0;
    while (!done && edges < 1400) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, "_done"}, {31'h0, done}, 32'd1);
  endtask

  task automatic run_case(input logic [7:0] a, input logic [7:0] b);
    int n;
    restart(a, b);
    wait_done("run", n);
    chk("run_gcd", {24'h0, gcd}, gcd_ref(a, b));
  endtask

  initial begin
    int n;
    logic [7:0] a, b, held;
    rst = 1'b0;
    opa = 8'd4;
    opb = 8'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gcd", {24'h0, gcd}, 32'd0);
    chk("reset_done", {31'h0, done}, 32'd0);

    // A=4, B=2: exact latency of 11 edges
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      #1;
      if (e < 11) chk("early_done", {31'h0, done}, 32'd0);
    end
    chk("lat11_done", {31'h0, done}, 32'd1);
    chk("lat11_gcd", {24'h0, gcd}, 32'd2);

    run_case(8'd12, 8'd18);
    run_case(8'd37, 8'd37);
    run_case(8'd0, 8'd9);
    run_case(8'd7, 8'd0);
    run_case(8'd0, 8'd0);

    restart(8'd255, 8'd1);
    wait_done("worst", n);
    chk("worst_gcd", {24'h0, gcd}, 32'd1);
    chk("worst_budget", {31'h0, n <= 1300}, 32'd1);

    for (int r = 0; r < 12; r++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run_case(a, b);
    end

    // Switch changes after the operand loads must not matter.
    restart(8'd48, 8'd36);
    repeat (4) @(posedge clk);
    #1;
    opa = 8'd17;
    opb = 8'd5;
    wait_done("late_sw", n);
    chk("late_sw_gcd", {24'h0, gcd}, 32'd12);

    // Halted: outputs hold while switches move, then a reset picks them up.
    held = gcd;
    for (int r = 0; r < 4; r++) begin
      opa = 8'($urandom_range(1, 255));
      opb = 8'($urandom_range(1, 255));
      repeat (7) @(posedge clk);
      #1;
      chk("hold_gcd", {24'h0, gcd}, {24'h0, held});
      chk("hold_done", {31'h0, done}, 32'd1);
    end
    opa = 8'd21;
    opb = 8'd14;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rerst_done", {31'h0, done}, 32'd0);
    chk("rerst_gcd", {24'h0, gcd}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_done("rerun", n);
    chk("rerun_gcd", {24'h0, gcd}, 32'd7);

    // Reset mid-loop aborts immediately, then the rerun completes.
    restart(8'd255, 8'd1);
    repeat (100) @(posedge clk);
    #1;
    chk("mid_busy", {31'h0, done}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_gcd", {24'h0, gcd}, 32'd0);
    chk("mid_done", {31'h0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_done("mid_rerun", n);
    chk("mid_rerun_gcd", {24'h0, gcd}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
